nn_layer_sequencer: RTL

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

---
 rtl/nn_layer_sequencer.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/nn_layer_sequencer.sv
// Control sequencer for a three-layer fully connected network: walks the weight and
// layer-IO BRAM address spaces and drives the MAC datapath strobes for one layer per start.
module nn_layer_sequencer #(
  parameter int RD_LAT = 1,
  parameter int N_IN   = 784,
  parameter int N_HID  = 20,
  parameter int N_OUT  = 10
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       start,
  input  logic [1:0] layer,
  output logic       busy,
  output logic       done,
  output logic [9:0] w_addr,
  output logic [9:0] io_rd_addr,
  output logic       mac_bias_load,
  output logic       mac_en,
  output logic       io_we,
  output logic [9:0] io_wr_addr,
  output logic [4:0] wb_idx
);

  localparam int KMAX01 = (N_IN > N_HID) ? N_IN : N_HID;
  localparam int KMAX02 = (KMAX01 > N_OUT) ? KMAX01 : N_OUT;
  localparam int KMAX   = (KMAX02 > RD_LAT) ? KMAX02 : RD_LAT;
  localparam int CW     = $clog2(KMAX + 1);

  localparam logic [9:0] WEIGHT_1   = 10'h000;
  localparam logic [9:0] WEIGHT_2   = 10'h312;
  localparam logic [9:0] WEIGHT_3   = 10'h327;
  localparam logic [9:0] INPUT_BASE = 10'h000;
  localparam logic [9:0] LAYER_IO_1 = 10'h310;
  localparam logic [9:0] LAYER_IO_2 = 10'h324;
  localparam logic [9:0] LAYER_IO_3 = 10'h338;

  typedef enum logic [2:0] {IDLE, BIAS, MAC, DRAIN, WB, DONE} state_t;

  state_t        state_q, state_d;
  logic [1:0]    layer_q, layer_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [CW-1:0] k_last, n_last;
  logic [9:0]    w_base, in_base, out_base;

  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [9:0]    w_addr_q, w_addr_d;
  logic [9:0]    io_rd_addr_q, io_rd_addr_d;
  logic          io_we_q, io_we_d;
  logic [9:0]    io_wr_addr_q, io_wr_addr_d;
  logic [4:0]    wb_idx_q, wb_idx_d;

  // Bit 0 marks the cycle a read is issued; bit RD_LAT marks when its data arrives.
  logic [RD_LAT:0] bias_pipe_q, bias_pipe_d;
  logic [RD_LAT:0] mac_pipe_q, mac_pipe_d;

  always_comb begin
    layer_d = layer_q;
    if (state_q == IDLE && start && layer != 2'd0) begin
      layer_d = layer;
    end
  end

  always_comb begin
    k_last   = CW'(N_IN - 1);
    n_last   = CW'(N_HID - 1);
    w_base   = WEIGHT_1;
    in_base  = INPUT_BASE;
    out_base = LAYER_IO_1;
    case (layer_d)
      2'd2: begin
        k_last   = CW'(N_HID - 1);
        n_last   = CW'(N_HID - 1);
        w_base   = WEIGHT_2;
        in_base  = LAYER_IO_1;
        out_base = LAYER_IO_2;
      end
      2'd3: begin
        k_last   = CW'(N_HID - 1);
        n_last   = CW'(N_OUT - 1);
        w_base   = WEIGHT_3;
        in_base  = LAYER_IO_2;
        out_base = LAYER_IO_3;
      end
      default: begin
        k_last   = CW'(N_IN - 1);
        n_last   = CW'(N_HID - 1);
        w_base   = WEIGHT_1;
        in_base  = INPUT_BASE;
        out_base = LAYER_IO_1;
      end
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (start && layer != 2'd0) begin
          state_d = BIAS;
          cnt_d   = '0;
        end
      end
      BIAS: begin
        state_d = MAC;
        cnt_d   = '0;
      end
      MAC: begin
        if (cnt_q == k_last) begin
          state_d = DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(RD_LAT - 1)) begin
          state_d = WB;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WB: begin
        if (cnt_q == n_last) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_comb begin
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == DONE);
    w_addr_d     = 10'h000;
    io_rd_addr_d = 10'h000;
    io_we_d      = 1'b0;
    io_wr_addr_d = 10'h000;
    wb_idx_d     = 5'd0;
    case (state_d)
      BIAS: begin
        w_addr_d = w_base - 10'd1;
      end
      MAC: begin
        w_addr_d     = w_base + 10'(cnt_d);
        io_rd_addr_d = in_base + 10'(cnt_d);
      end
      WB: begin
        io_we_d      = 1'b1;
        io_wr_addr_d = out_base + 10'(cnt_d);
        wb_idx_d     = 5'(cnt_d);
      end
      default: begin
        w_addr_d     = 10'h000;
        io_rd_addr_d = 10'h000;
      end
    endcase
    bias_pipe_d = {bias_pipe_q[RD_LAT-1:0], (state_d == BIAS)};
    mac_pipe_d  = {mac_pipe_q[RD_LAT-1:0], (state_d == MAC)};
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      layer_q      <= 2'd0;
      cnt_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      w_addr_q     <= 10'h000;
      io_rd_addr_q <= 10'h000;
      io_we_q      <= 1'b0;
      io_wr_addr_q <= 10'h000;
      wb_idx_q     <= 5'd0;
      bias_pipe_q  <= '0;
      mac_pipe_q   <= '0;
    end else begin
      state_q      <= state_d;
      layer_q      <= layer_d;
      cnt_q        <= cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      w_addr_q     <= w_addr_d;
      io_rd_addr_q <= io_rd_addr_d;
      io_we_q      <= io_we_d;
      io_wr_addr_q <= io_wr_addr_d;
      wb_idx_q     <= wb_idx_d;
      bias_pipe_q  <= bias_pipe_d;
      mac_pipe_q   <= mac_pipe_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign w_addr        = w_addr_q;
  assign io_rd_addr    = io_rd_addr_q;
  assign mac_bias_load = bias_pipe_q[RD_LAT];
  assign mac_en        = mac_pipe_q[RD_LAT];
  assign io_we         = io_we_q;
  assign io_wr_addr    = io_wr_addr_q;
  assign wb_idx        = wb_idx_q;

endmodule
